// File: rtl/player_motion_if.sv
// Move-command handshake between a command source and player_motion_ctrl.
interface player_motion_if;
    logic       move_valid;
    logic       move_ready;
    logic [9:0] move_tx;
    logic [9:0] move_ty;

    modport master (
        output move_valid,
        output move_tx,
        output move_ty,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_tx,
        input  move_ty,
        output move_ready
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player sprite position animator: steps toward a commanded target on frame ticks, X then Y.
// Optional hop animation on player_y is enabled by defining PLAYER_BOUNCE_EN.
module player_motion_ctrl #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPRITE_SZ = 16,
    parameter int STEP_PX   = 4,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             halt,
    player_motion_if.slave   mv,
    output logic [9:0]       player_x,
    output logic [9:0]       player_y,
    output logic             moving,
    output logic             arrived
);

    localparam logic [9:0]        X_LIM  = 10'(SCREEN_W - SPRITE_SZ);
    localparam logic [9:0]        Y_LIM  = 10'(SCREEN_H - SPRITE_SZ);
    localparam logic [9:0]        STEP_U = 10'(STEP_PX);
    localparam logic signed [10:0] STEP_P = 11'(STEP_PX);
    localparam logic signed [10:0] STEP_N = 11'(-STEP_PX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE_X = 2'd1,
        ST_MOVE_Y = 2'd2
    } state_t;

    state_t     state_q;
    logic [9:0] x_q, y_q, tx_q, ty_q;
    logic [9:0] x_d, y_d;
    logic       moving_q, arrived_q;

    // One frame's worth of motion; the last step lands exactly on the target.
    function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
        logic signed [10:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_P) begin
            return cur + STEP_U;
        end else if (diff < STEP_N) begin
            return cur - STEP_U;
        end else begin
            return tgt;
        end
    endfunction

    // Candidate next positions for the current targets.
    always_comb begin
        x_d = step_toward(x_q, tx_q);
        y_d = step_toward(y_q, ty_q);
    end

    // Motion FSM; halt beats both frame_tick and a same-cycle command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= 10'(INIT_X);
            y_q       <= 10'(INIT_Y);
            tx_q      <= 10'(INIT_X);
            ty_q      <= 10'(INIT_Y);
            moving_q  <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            arrived_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!halt && mv.move_valid) begin
                        tx_q     <= (mv.move_tx > X_LIM) ? X_LIM : mv.move_tx;
                        ty_q     <= (mv.move_ty > Y_LIM) ? Y_LIM : mv.move_ty;
                        state_q  <= ST_MOVE_X;
                        moving_q <= 1'b1;
                    end
                end
                ST_MOVE_X: begin
                    if (halt) begin
                        tx_q     <= x_q;
                        ty_q     <= y_q;
                        state_q  <= ST_IDLE;
                        moving_q <= 1'b0;
                    end else if (frame_tick) begin
                        if (x_q != tx_q) begin
                            x_q <= x_d;
                        end else begin
                            state_q <= ST_MOVE_Y;
                        end
                    end
                end
                ST_MOVE_Y: begin
                    if (halt) begin
                        tx_q     <= x_q;
                        ty_q     <= y_q;
                        state_q  <= ST_IDLE;
                        moving_q <= 1'b0;
                    end else if (frame_tick) begin
                        if (y_q != ty_q) begin
                            y_q <= y_d;
                        end else begin
                            state_q   <= ST_IDLE;
                            moving_q  <= 1'b0;
                            arrived_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    moving_q <= 1'b0;
                end
            endcase
        end
    end

    assign mv.move_ready = (state_q == ST_IDLE);
    assign player_x      = x_q;
    assign moving        = moving_q;
    assign arrived       = arrived_q;

`ifdef PLAYER_BOUNCE_EN
    logic [2:0] fcnt_q;

    // Free-running frame counter that phases the hop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt_q <= 3'd0;
        end else if (frame_tick) begin
            fcnt_q <= fcnt_q + 3'd1;
        end else begin
            fcnt_q <= fcnt_q;
        end
    end

    assign player_y = (moving_q && fcnt_q[2]) ? ((y_q < 10'd2) ? 10'd0 : (y_q - 10'd2)) : y_q;
`else
    assign player_y = y_q;
`endif

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Randomized self-checking bench for player_motion_ctrl against a transaction-level motion model.
module tb_player_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       halt = 1'b0;
    logic [9:0] player_x, player_y;
    logic       moving, arrived;

    player_motion_if mif ();

    player_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .halt       (halt),
        .mv         (mif),
        .player_x   (player_x),
        .player_y   (player_y),
        .moving     (moving),
        .arrived    (arrived)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int mx = 0, my = 0;
    int ticks = 0;
    bit mmov = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_py();
`ifdef PLAYER_BOUNCE_EN
        if (mmov && (ticks % 8) >= 4) return (my < 2) ? 0 : my - 2;
`endif
        return my;
    endfunction

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic int step_to(input int c, input int t);
        if (t > c) return c + ((t - c) < 4 ? (t - c) : 4);
        return c - ((c - t) < 4 ? (c - t) : 4);
    endfunction

    task automatic check_state(input string tag, input bit mov, input bit arr);
        check_eq({tag, ":x"}, 32'(player_x), 32'(mx));
        check_eq({tag, ":y"}, 32'(player_y), 32'(exp_py()));
        check_eq({tag, ":moving"}, 32'(moving), 32'(mov));
        check_eq({tag, ":arrived"}, 32'(arrived), 32'(arr));
        check_eq({tag, ":ready"}, 32'(mif.move_ready), 32'(!mov));
    endtask

    task automatic gap(input int max_gap);
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    endtask

    task automatic do_tick(input bit h);
        @(negedge clk);
        frame_tick = 1'b1;
        halt       = h;
        @(negedge clk);
        frame_tick = 1'b0;
        halt       = 1'b0;
        ticks++;
    endtask

    task automatic accept(input int tx, input int ty, input bit with_tick);
        check_eq("pre_accept:ready", 32'(mif.move_ready), 32'd1);
        @(negedge clk);
        mif.move_valid = 1'b1;
        mif.move_tx    = 10'(tx);
        mif.move_ty    = 10'(ty);
        frame_tick     = with_tick;
        @(negedge clk);
        mif.move_valid = 1'b0;
        frame_tick     = 1'b0;
        if (with_tick) ticks++;
        mmov = 1'b1;
        check_state("accept", 1'b1, 1'b0);
    endtask

    task automatic run_move(input int tx, input int ty, input bit tick_acc, input int max_gap);
        int ctx, cty;
        ctx = clampv(tx, 624);
        cty = clampv(ty, 464);
        accept(tx, ty, tick_acc);
        while (mx != ctx) begin
            gap(max_gap);
            do_tick(1'b0);
            mx = step_to(mx, ctx);
            check_state("move_x", 1'b1, 1'b0);
        end
        gap(max_gap);
        do_tick(1'b0);
        check_state("turn", 1'b1, 1'b0);
        while (my != cty) begin
            gap(max_gap);
            do_tick(1'b0);
            my = step_to(my, cty);
            check_state("move_y", 1'b1, 1'b0);
        end
        gap(max_gap);
        do_tick(1'b0);
        mmov = 1'b0;
        check_state("arrive", 1'b0, 1'b1);
        @(negedge clk);
        check_state("post_arrive", 1'b0, 1'b0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mif.move_valid = 1'b0;
        mif.move_tx    = 10'd0;
        mif.move_ty    = 10'd0;
        repeat (3) @(negedge clk);
        check_state("reset", 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_state("after_reset", 1'b0, 1'b0);

        run_move(40, 0, 1'b0, 0);
        run_move(0, 0, 1'b0, 1);
        run_move(10, 6, 1'b0, 0);
        run_move(1000, 900, 1'b0, 1);
        check_eq("clamp:x", 32'(player_x), 32'd624);
        check_eq("clamp:y", 32'(player_y), 32'd464);
        run_move(624, 464, 1'b0, 2);
        run_move(300, 200, 1'b1, 1);

        // Halt mid-move, coincident with a frame tick.
        accept(100, 50, 1'b0);
        repeat (3) begin
            do_tick(1'b0);
            mx = step_to(mx, 100);
            check_state("pre_halt", 1'b1, 1'b0);
        end
        do_tick(1'b1);
        mmov = 1'b0;
        check_state("halt", 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check_state("halt_idle", 1'b0, 1'b0);
        end

        // Halt in IDLE blocks a same-cycle command.
        @(negedge clk);
        mif.move_valid = 1'b1;
        mif.move_tx    = 10'd500;
        mif.move_ty    = 10'd10;
        halt           = 1'b1;
        @(negedge clk);
        mif.move_valid = 1'b0;
        halt           = 1'b0;
        check_state("halt_blocks_accept", 1'b0, 1'b0);
        do_tick(1'b0);
        check_state("halt_blocks_tick", 1'b0, 1'b0);

        run_move(0, 0, 1'b0, 1);

        // Asynchronous reset in the middle of a move.
        accept(200, 100, 1'b0);
        repeat (5) begin
            do_tick(1'b0);
            mx = step_to(mx, 200);
        end
        check_state("pre_reset", 1'b1, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        mx = 0; my = 0; mmov = 1'b0; ticks = 0;
        check_state("async_reset", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_state("post_reset", 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_move(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                     1'($urandom_range(1, 0)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
